alt_mem_ddrx_ecc_decoder_mlane: RTL

Multi-lane, pipelined SECDED decoder for the DDRx controller read-data path, placed between the read-data FIFO and the local read-return logic. It replaces the fixed single-lane wrapper, and each 72-bit lane is decoded as a (72,64) extended Hamming word. It adds per-beat control-bit pipelining, saturating error statistics, first-error address capture and a clearable interrupt for the CSR block.

---
 rtl/alt_mem_ddrx_ecc_decoder_mlane_pkg.sv | 34 +++
 rtl/alt_mem_ddrx_ecc_decoder_mlane_lane.sv | 50 +++++
 rtl/alt_mem_ddrx_ecc_decoder_mlane.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alt_mem_ddrx_ecc_decoder_mlane_pkg.sv
// alt_mem_ddrx_ecc_decoder_mlane_pkg: lane geometry, data-bit position map and error classes.
// Revision 1.0
`default_nettype none

package alt_mem_ddrx_ecc_decoder_mlane_pkg;

  localparam int LANE_W = 72;
  localparam int DATA_W = 64;
  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CORR  = 2'd1,
    FATAL = 2'd2
  } ecc_class_e;

  // Codeword position (1..71) that carries data bit idx; powers of two hold check bits.
  function automatic logic [6:0] data_pos(input int idx);
    int         n;
    logic [6:0] pos;
    n   = 0;
    pos = '0;
    for (int p = 1; p < LANE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = 7'(p);
        n = n + 1;
      end
    end
    return pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alt_mem_ddrx_ecc_decoder_mlane_lane.sv
// alt_mem_ddrx_ecc_secded_lane: combinational (72,64) SECDED check and single-bit correction.
// Revision 1.0
`default_nettype none

module alt_mem_ddrx_ecc_secded_lane
  import alt_mem_ddrx_ecc_decoder_mlane_pkg::*;
(
  input  logic [LANE_W-1:0] codeword,
  output logic [DATA_W-1:0] data,
  output logic              corrected,
  output logic              fatal
);

  logic [6:0] syndrome;
  logic       parity;
  ecc_class_e err_class;

  always_comb begin
    syndrome = codeword[DATA_W +: 7];
    for (int i = 0; i < DATA_W; i++) begin
      syndrome = syndrome ^ (data_pos(i) & {7{codeword[i]}});
    end
    parity = ^codeword;
  end

  // Odd parity means one flipped bit unless the syndrome points past the codeword.
  always_comb begin
    err_class = CLEAN;
    if (parity) begin
      err_class = (syndrome < 7'd72) ? CORR : FATAL;
    end else if (syndrome != '0) begin
      err_class = FATAL;
    end
  end

  always_comb begin
    data = codeword[DATA_W-1:0];
    if (err_class == CORR) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (syndrome == data_pos(i)) data[i] = ~codeword[i];
      end
    end
  end

  assign corrected = (err_class == CORR);
  assign fatal     = (err_class == FATAL);

endmodule

`default_nettype wire

// File: rtl/alt_mem_ddrx_ecc_decoder_mlane.sv
// alt_mem_ddrx_ecc_decoder_mlane: pipelined multi-lane SECDED decoder with error statistics.
// Revision 1.0
`default_nettype none

module alt_mem_ddrx_ecc_decoder_mlane
  import alt_mem_ddrx_ecc_decoder_mlane_pkg::*;
#(
  parameter int CFG_LANES       = 2,
  parameter int CFG_ECC_DEC_REG = 1,
  parameter int CFG_ADDR_WIDTH  = 32,
  parameter int CFG_CNT_WIDTH   = 16
) (
  input  logic                          ctl_clk,
  input  logic                          ctl_reset_n,
  input  logic                          cfg_enable_ecc,
  input  logic                          cfg_enable_intr,
  input  logic                          cfg_err_clr,
  input  logic [LANE_W*CFG_LANES-1:0]   input_data,
  input  logic                          input_data_valid,
  input  logic [CFG_ADDR_WIDTH-1:0]     input_addr,
  output logic [LANE_W*CFG_LANES-1:0]   output_data,
  output logic                          output_data_valid,
  output logic [CODE_W*CFG_LANES-1:0]   output_ecc_code,
  output logic [CFG_LANES-1:0]          err_corrected,
  output logic [CFG_LANES-1:0]          err_detected,
  output logic [CFG_LANES-1:0]          err_fatal,
  output logic [CFG_CNT_WIDTH-1:0]      sbe_count,
  output logic [CFG_CNT_WIDTH-1:0]      dbe_count,
  output logic [CFG_ADDR_WIDTH-1:0]     err_addr,
  output logic                          err_addr_valid,
  output logic                          err_addr_fatal,
  output logic                          err_intr
);

  localparam int BUS_W  = LANE_W * CFG_LANES;
  localparam int CODE_BW = CODE_W * CFG_LANES;
  localparam int SUM_W  = CFG_CNT_WIDTH + 4;

  logic                      s1_valid;
  logic                      s1_en;
  logic [BUS_W-1:0]          s1_data;
  logic [CFG_ADDR_WIDTH-1:0] s1_addr;

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= input_data_valid;
      s1_en    <= cfg_enable_ecc;
      s1_data  <= input_data;
      s1_addr  <= input_addr;
    end
  end

  logic [BUS_W-1:0]     dec_data;
  logic [CODE_BW-1:0]   dec_code;
  logic [CFG_LANES-1:0] dec_corr;
  logic [CFG_LANES-1:0] dec_fatal;

  // The enable travels with the beat, so raw pass-through is chosen per beat here.
  for (genvar k = 0; k < CFG_LANES; k++) begin : g_lane
    logic [DATA_W-1:0] lane_fixed;
    logic              lane_corr;
    logic              lane_fatal;

    alt_mem_ddrx_ecc_secded_lane u_lane (
      .codeword  (s1_data[k*LANE_W +: LANE_W]),
      .data      (lane_fixed),
      .corrected (lane_corr),
      .fatal     (lane_fatal)
    );

    assign dec_data[k*LANE_W +: LANE_W] = s1_en ? {{CODE_W{1'b0}}, lane_fixed}
                                                : s1_data[k*LANE_W +: LANE_W];
    assign dec_code[k*CODE_W +: CODE_W] = s1_en ? s1_data[k*LANE_W+DATA_W +: CODE_W] : '0;
    assign dec_corr[k]  = s1_valid & s1_en & lane_corr;
    assign dec_fatal[k] = s1_valid & s1_en & lane_fatal;
  end

  logic [CFG_ADDR_WIDTH-1:0] out_addr;

  if (CFG_ECC_DEC_REG != 0) begin : g_dec_reg
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
      if (!ctl_reset_n) begin
        output_data       <= '0;
        output_data_valid <= 1'b0;
        output_ecc_code   <= '0;
        err_corrected     <= '0;
        err_fatal         <= '0;
        out_addr          <= '0;
      end else begin
        output_data       <= dec_data;
        output_data_valid <= s1_valid;
        output_ecc_code   <= dec_code;
        err_corrected     <= dec_corr;
        err_fatal         <= dec_fatal;
        out_addr          <= s1_addr;
      end
    end
  end else begin : g_dec_comb
    assign output_data       = dec_data;
    assign output_data_valid = s1_valid;
    assign output_ecc_code   = dec_code;
    assign err_corrected     = dec_corr;
    assign err_fatal         = dec_fatal;
    assign out_addr          = s1_addr;
  end

  assign err_detected = err_corrected | err_fatal;

  function automatic logic [CFG_CNT_WIDTH-1:0] sat_add(input logic [CFG_CNT_WIDTH-1:0] base,
                                                       input logic [3:0] inc);
    logic [SUM_W-1:0] sum;
    sum = {4'b0000, base} + {{CFG_CNT_WIDTH{1'b0}}, inc};
    return (sum[SUM_W-1:CFG_CNT_WIDTH] != '0) ? '1 : sum[CFG_CNT_WIDTH-1:0];
  endfunction

  logic [CFG_LANES-1:0]      beat_corr;
  logic [CFG_LANES-1:0]      beat_fatal;
  logic                      beat_err;
  logic                      beat_any_fatal;
  logic [3:0]                sbe_inc;
  logic [3:0]                dbe_inc;
  logic [CFG_CNT_WIDTH-1:0]  sbe_next;
  logic [CFG_CNT_WIDTH-1:0]  dbe_next;
  logic [CFG_ADDR_WIDTH-1:0] cap_addr_next;
  logic                      cap_valid_next;
  logic                      cap_fatal_next;
  logic                      intr_next;

  always_comb begin
    beat_corr      = output_data_valid ? err_corrected : '0;
    beat_fatal     = output_data_valid ? err_fatal : '0;
    beat_err       = |(beat_corr | beat_fatal);
    beat_any_fatal = |beat_fatal;
    sbe_inc        = '0;
    dbe_inc        = '0;
    for (int k = 0; k < CFG_LANES; k++) begin
      sbe_inc = sbe_inc + 4'(beat_corr[k]);
      dbe_inc = dbe_inc + 4'(beat_fatal[k]);
    end
    sbe_next = sat_add(cfg_err_clr ? '0 : sbe_count, sbe_inc);
    dbe_next = sat_add(cfg_err_clr ? '0 : dbe_count, dbe_inc);

    cap_addr_next  = cfg_err_clr ? '0 : err_addr;
    cap_valid_next = cfg_err_clr ? 1'b0 : err_addr_valid;
    cap_fatal_next = cfg_err_clr ? 1'b0 : err_addr_fatal;
    // An empty capture takes any error; a correctable one is upgraded once by a fatal.
    if (beat_err && (!cap_valid_next || (beat_any_fatal && !cap_fatal_next))) begin
      cap_addr_next  = out_addr;
      cap_valid_next = 1'b1;
      cap_fatal_next = beat_any_fatal;
    end

    intr_next = (err_intr & ~cfg_err_clr) | (beat_err & cfg_enable_intr);
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      sbe_count      <= '0;
      dbe_count      <= '0;
      err_addr       <= '0;
      err_addr_valid <= 1'b0;
      err_addr_fatal <= 1'b0;
      err_intr       <= 1'b0;
    end else begin
      sbe_count      <= sbe_next;
      dbe_count      <= dbe_next;
      err_addr       <= cap_addr_next;
      err_addr_valid <= cap_valid_next;
      err_addr_fatal <= cap_fatal_next;
      err_intr       <= intr_next;
    end
  end

endmodule

`default_nettype wire
